// File: rtl/cpu_pkg.sv
// cpu_pkg: shared datapath widths, operand types and the shifter opcode encoding
package cpu_pkg;
  localparam int DATA_W = 16;
  localparam int NREGS = 8;
  localparam int AW = $clog2(NREGS);
  typedef logic [AW-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;
  typedef enum logic [1:0] {
    NOSHIFT = 2'b00,
    LSL     = 2'b01,
    LSR     = 2'b10,
    ASR     = 2'b11
  } shift_op_t;
endpackage

// File: rtl/operand_stage_if.sv
// operand_stage_if: register-file write port, operand loads and operand outputs
interface operand_stage_if import cpu_pkg::*; ();
  logic      write;
  reg_addr_t writenum;
  word_t     data_in;
  reg_addr_t readnum;
  logic      loada;
  logic      loadb;
  word_t     a_out;
  word_t     b_out;
  logic      b_valid;
  modport master (
    output write, writenum, data_in, readnum, loada, loadb,
    input  a_out, b_out, b_valid
  );
  modport slave (
    input  write, writenum, data_in, readnum, loada, loadb,
    output a_out, b_out, b_valid
  );
endinterface

// File: rtl/operand_stage_regfile.sv
// regfile: 8x16 storage with one write port and a write-through forwarded read
module regfile import cpu_pkg::*; (
  input  logic      clk,
  input  logic      rst,
  input  logic      write_i,
  input  reg_addr_t writenum_i,
  input  word_t     data_in_i,
  input  reg_addr_t readnum_i,
  output word_t     rd_o
);
  word_t mem_q [NREGS];
  word_t mem_d [NREGS];
  always_comb begin
    mem_d = mem_q;
    if (write_i) mem_d[writenum_i] = data_in_i;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_q <= '{default: '0};
    else mem_q <= mem_d;
  end
  assign rd_o = (write_i && writenum_i == readnum_i) ? data_in_i : mem_q[readnum_i];
endmodule

// File: rtl/operand_stage.sv
// operand_stage: register file plus A/B operand registers feeding the ALU and shifter
module operand_stage import cpu_pkg::*; (
  input logic clk,
  input logic rst,
  operand_stage_if.slave bus
);
  word_t rd;
  word_t a_q, a_d, b_q, b_d;
  logic  bv_q, bv_d;
  regfile u_rf (
    .clk       (clk),
    .rst       (rst),
    .write_i   (bus.write),
    .writenum_i(bus.writenum),
    .data_in_i (bus.data_in),
    .readnum_i (bus.readnum),
    .rd_o      (rd)
  );
  always_comb begin
    a_d  = bus.loada ? rd : a_q;
    b_d  = bus.loadb ? rd : b_q;
    bv_d = bv_q | bus.loadb;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      bv_q <= 1'b0;
    end else begin
      a_q  <= a_d;
      b_q  <= b_d;
      bv_q <= bv_d;
    end
  end
  assign bus.a_out   = a_q;
  assign bus.b_out   = b_q;
  assign bus.b_valid = bv_q;
endmodule

// File: doc/operand_stage.md
# operand_stage

Operand stage of the simple CPU datapath, sitting directly upstream of the shifter. It holds an 8-entry × 16-bit register file and two pipeline operand registers, A and B. B drives the shifter's 16-bit `shift_in`; A bypasses the shifter toward the ALU. Writeback data re-enters through the write port, and same-cycle write/read collisions are forwarded so the shifter always sees the freshest value.

## Interface
- `DATA_W`, 16, datapath word width; must equal the shifter width.
- `NREGS`, 8, register count; must be a power of two.
- `AW`, $clog2(NREGS) = 3, register address width; derived, not overridable.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `write`  in  1  register-file write enable.
- `writenum`  in  AW  write address.
- `data_in`  in  DATA_W  write data (writeback from ALU/immediate mux).
- `readnum`  in  AW  read address, shared by both operand loads.
- `loada`  in  1  capture read data into A.
- `loadb`  in  1  capture read data into B.
- `a_out`  out  DATA_W  operand A register.
- `b_out`  out  DATA_W  operand B register; connects to shifter `shift_in`.
- `b_valid`  out  1  B holds data loaded since reset.

## Operation
- Register file: on a clock edge with `write`=1, `R[writenum] <= data_in`. No write when `write`=0.
- Read data `rd` is combinational:
  - `rd = data_in` when `write` && `writenum==readnum` (write-through forwarding).
  - Otherwise `rd = R[readnum]`.
- A: on a clock edge with `loada`=1, `A <= rd`; otherwise A holds.
- B: on a clock edge with `loadb`=1, `B <= rd`; otherwise B holds.
- `loada` and `loadb` asserted together: both capture the same `rd`.
- `b_valid`: set on the first `loadb`; stays set until reset.
- Write and load in the same cycle to the same address:
  - the register file takes `data_in`;
  - A/B also take `data_in`, never the stale value.
- Write and load to different addresses: fully independent.
- All address values are in range because `NREGS` is a power of two, so there is no out-of-range case. Addresses are not wrapped or checked.
- No arithmetic is performed; widths match exactly, with no truncation or extension.

## Timing
- Reset: while `rst`=1, asynchronously:
  - all R[i] = 0;
  - `a_out` = 0, `b_out` = 0, `b_valid` = 0.
  - Loads and writes are ignored while reset is held.
- Reset asserted mid-operation clears state immediately, without waiting for `clk`. An in-flight write in that cycle is lost.
- Write-to-readback latency: 1 cycle. A value written at edge N is readable from R at edge N+1; forwarding makes it loadable at edge N itself.
- Load latency: `a_out`/`b_out` update 1 cycle after the `loadX` edge. The shifter output is then combinational off `b_out`.
- Outputs change only on `clk` edges or on `rst` assertion; they are glitch-free registered outputs.

## Structure
- Shared package `cpu_pkg`:
  - `DATA_W`, `AW`;
  - `reg_addr_t` (logic [AW-1:0]);
  - `word_t` (logic [DATA_W-1:0]);
  - `shift_op_t` enum, shared with the shifter: NOSHIFT=2'b00, LSL=2'b01, LSR=2'b10, ASR=2'b11.
- One sub-module: `regfile`, holding the storage array and write port, with a combinational read and the forwarding mux.
- The `operand_stage` top holds the A/B registers and `b_valid`.

## Test plan
- Reset: assert `rst` asynchronously between edges -> `a_out`=0, `b_out`=0, `b_valid`=0 at once. After release, loading every address gives 0.
- Write/read: write R3=16'd8; next cycle `readnum`=3, `loadb`=1 -> `b_out`=16'd8, `b_valid`=1. Shifter LSL result = 16'd16.
- Forwarding: R5=16'd4 initially; same cycle `write`=1, `writenum`=5, `data_in`=16'hC000, `readnum`=5, `loadb`=1 -> `b_out`=16'hC000. Shifter ASR result = 16'hE000.
- Dual load: R1=16'h1234; `loada`=`loadb`=1, `readnum`=1 -> both `a_out` and `b_out` = 16'h1234. Next cycle with no loads, both outputs hold.
- Independent write: write R2=16'hFFFF while loading B from R6=16'd0 -> `b_out`=0. R2 reads 16'hFFFF on the following cycle.
- Reset mid-operation: fill R0–R7 with 16'd1…16'd8, pulse `rst` during a write cycle -> all registers and outputs read 0. The pending write is not committed.
